fig3p37_sweep_checker: RTL and testbench

- Sequential stimulus/response companion for the three-input gate block (A, B, C in; D, E out).
- Drives all 8 input combinations in order and holds each for a programmable settle time.
- Samples D/E at the end of each hold and checks them against the golden equations:
  - D = (A & B) ^ ~C
  - E = ~C
- Reports an error count, a per-vector fail map and a pass/done flag.
- Sits on the opposite side of the gate block's ports: it drives that block's inputs and consumes its outputs. It replaces hand-written timeline stimulus in lab benches and on-board checks.

---
 rtl/fig3p37_sweep_checker.sv | 107 ++++++++++
 tb/tb_fig3p37_sweep_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fig3p37_sweep_checker.sv
// rtl/fig3p37_sweep_checker.sv - exhaustive 3-input sweep driver and checker for the fig3p37 gate block
// Steps A/B/C through 000..111, holds each HOLD_CYCLES clocks and checks D/E on the last one.
module fig3p37_sweep_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             D,
  input  logic             E,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_vec
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [HC_W-1:0]  r_hold_cnt;
  logic [2:0]       r_abc;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_count;
  logic [7:0]       r_fail_vec;

  logic             w_exp_d;
  logic             w_exp_e;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  // Golden values come from the driven stimulus, not r_idx, so a stimulus bug shows up as mismatches.
  assign w_exp_d    = (r_abc[2] & r_abc[1]) ^ ~r_abc[0];
  assign w_exp_e    = ~r_abc[0];
  assign w_mismatch = (D != w_exp_d) || (E != w_exp_e);
  assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_hold_cnt  <= '0;
      r_abc       <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_vec  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_DRIVE;
            r_idx       <= 3'd0;
            r_hold_cnt  <= '0;
            r_abc       <= 3'd0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= 8'h00;
          end
        end
        S_DRIVE: begin
          if (r_hold_cnt != HC_LAST) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end else begin
            r_hold_cnt  <= '0;
            r_err_count <= w_err_next;
            if (w_mismatch) r_fail_vec[r_idx] <= 1'b1;
            if (r_idx != 3'd7) begin
              r_idx <= r_idx + 3'd1;
              r_abc <= r_idx + 3'd1;
            end else begin
              r_state <= S_DONE;
              r_abc   <= 3'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A         = r_abc[2];
  assign B         = r_abc[1];
  assign C         = r_abc[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_fig3p37_sweep_checker.sv
// tb/tb_fig3p37_sweep_checker.sv - directed bench for fig3p37_sweep_checker
module tb_fig3p37_sweep_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // u0: HOLD=4 ERR_W=4 with selectable gate fault; u1: HOLD=4 ERR_W=2 with D inverted; u2: HOLD=1
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  int         mode0 = 0;
  logic       a0, b0, c0, d0, e0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [7:0] fv0;
  logic       a1, b1, c1, d1, e1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [7:0] fv1;
  logic       a2, b2, c2, d2, e2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [7:0] fv2;

  assign d0 = (mode0 == 2) ? ~((a0 & b0) ^ ~c0) : ((a0 & b0) ^ ~c0);
  assign e0 = (mode0 == 1) ? 1'b0 : ~c0;
  assign d1 = ~((a1 & b1) ^ ~c1);
  assign e1 = ~c1;
  assign d2 = (a2 & b2) ^ ~c2;
  assign e2 = ~c2;

  fig3p37_sweep_checker #(.HOLD_CYCLES(4), .ERR_W(4)) u0 (
    .clk(clk), .reset(reset), .start(start0), .A(a0), .B(b0), .C(c0), .D(d0), .E(e0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0));
  fig3p37_sweep_checker #(.HOLD_CYCLES(4), .ERR_W(2)) u1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1), .C(c1), .D(d1), .E(e1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));
  fig3p37_sweep_checker #(.HOLD_CYCLES(1), .ERR_W(4)) u2 (
    .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2), .C(c2), .D(d2), .E(e2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2));

  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  // Pulses start on one instance and returns edges from the start edge to done (-1 on timeout).
  task automatic run_sweep(input int which, output int edges);
    edges = -1;
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    tick();
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (get_done(which)) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({a0, b0, c0, busy0, done0, pass0} !== 6'b0) begin
      bad++; $display("FAIL reset_bits got=%b exp=000000", {a0, b0, c0, busy0, done0, pass0});
    end
    total++;
    if (err0 !== 4'd0 || fv0 !== 8'h00) begin
      bad++; $display("FAIL reset_counts got err=%0d fv=%h exp err=0 fv=00", err0, fv0);
    end
  endtask

  task automatic test_correct_sweep();
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++;
    if (busy0 !== 1'b1 || {a0, b0, c0} !== 3'd0) begin
      bad++; $display("FAIL sweep_start got busy=%b abc=%b exp busy=1 abc=000", busy0, {a0, b0, c0});
    end
    for (int e = 1; e <= 31; e++) begin
      tick();
      total++;
      if ({a0, b0, c0} !== 3'(e / 4) || done0 !== 1'b0) begin
        bad++; $display("FAIL sweep_step edge=%0d got abc=%b done=%b exp abc=%b done=0",
                        e, {a0, b0, c0}, done0, 3'(e / 4));
      end
    end
    tick();
    total++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== 1'b1) begin
      bad++; $display("FAIL sweep_done got done=%b busy=%b pass=%b exp 1 0 1", done0, busy0, pass0);
    end
    total++;
    if (err0 !== 4'd0 || fv0 !== 8'h00 || {a0, b0, c0} !== 3'd0) begin
      bad++; $display("FAIL sweep_result got err=%0d fv=%h abc=%b exp err=0 fv=00 abc=000", err0, fv0, {a0, b0, c0});
    end
  endtask

  task automatic test_e_stuck();
    int edges;
    mode0 = 1;
    run_sweep(0, edges);
    total++;
    if (edges !== 32) begin
      bad++; $display("FAIL estuck_latency got=%0d exp=32", edges);
    end
    total++;
    if (err0 !== 4'd4 || fv0 !== 8'h55 || pass0 !== 1'b0) begin
      bad++; $display("FAIL estuck_result got err=%0d fv=%h pass=%b exp err=4 fv=55 pass=0", err0, fv0, pass0);
    end
  endtask

  task automatic test_restart_in_done();
    int edges;
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || err0 !== 4'd0 || fv0 !== 8'h00) begin
      bad++; $display("FAIL restart_clear got done=%b busy=%b err=%0d fv=%h exp 0 1 0 00", done0, busy0, err0, fv0);
    end
    edges = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (done0) begin
        edges = n;
        break;
      end
    end
    total++;
    if (edges !== 32 || pass0 !== 1'b1) begin
      bad++; $display("FAIL restart_run got edges=%0d pass=%b exp edges=32 pass=1", edges, pass0);
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++;
    if ({a0, b0, c0} !== 3'd2 || busy0 !== 1'b1) begin
      bad++; $display("FAIL ignore_midsweep got abc=%b busy=%b exp abc=010 busy=1", {a0, b0, c0}, busy0);
    end
    edges = -1;
    for (int n = 11; n <= 60; n++) begin
      tick();
      if (done0) begin
        edges = n;
        break;
      end
    end
    total++;
    if (edges !== 32 || pass0 !== 1'b1) begin
      bad++; $display("FAIL ignore_done got edges=%0d pass=%b exp edges=32 pass=1", edges, pass0);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    mode0 = 1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int n = 1; n <= 12; n++) tick();
    total++;
    if (err0 !== 4'd2) begin
      bad++; $display("FAIL midreset_pre got err=%0d exp=2", err0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({a0, b0, c0, busy0, done0, pass0} !== 6'b0 || err0 !== 4'd0 || fv0 !== 8'h00) begin
      bad++; $display("FAIL midreset_clear got bits=%b err=%0d fv=%h exp bits=000000 err=0 fv=00",
                      {a0, b0, c0, busy0, done0, pass0}, err0, fv0);
    end
    for (int n = 0; n < 6; n++) tick();
    total++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      bad++; $display("FAIL midreset_idle got busy=%b done=%b exp 0 0", busy0, done0);
    end
    mode0 = 0;
    run_sweep(0, edges);
    total++;
    if (edges !== 32 || pass0 !== 1'b1 || err0 !== 4'd0) begin
      bad++; $display("FAIL midreset_rerun got edges=%0d pass=%b err=%0d exp 32 1 0", edges, pass0, err0);
    end
  endtask

  task automatic test_saturate();
    int edges;
    run_sweep(1, edges);
    total++;
    if (edges !== 32) begin
      bad++; $display("FAIL sat_latency got=%0d exp=32", edges);
    end
    total++;
    if (err1 !== 2'd3 || fv1 !== 8'hFF || pass1 !== 1'b0) begin
      bad++; $display("FAIL sat_result got err=%0d fv=%h pass=%b exp err=3 fv=ff pass=0", err1, fv1, pass1);
    end
  endtask

  task automatic test_hold1();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      if (e > 0) tick();
      total++;
      if ({a2, b2, c2} !== 3'(e) || done2 !== 1'b0) begin
        bad++; $display("FAIL hold1_step edge=%0d got abc=%b done=%b exp abc=%b done=0", e, {a2, b2, c2}, done2, 3'(e));
      end
    end
    tick();
    total++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 4'd0 || fv2 !== 8'h00) begin
      bad++; $display("FAIL hold1_done got done=%b pass=%b err=%0d fv=%h exp 1 1 0 00", done2, pass2, err2, fv2);
    end
  endtask

  initial begin
    test_reset();
    test_correct_sweep();
    test_e_stuck();
    test_restart_in_done();
    test_ignore_start();
    test_reset_mid();
    test_saturate();
    test_hold1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
